axi_master_arbiter_w: RTL and testbench

- Round-robin write-channel arbiter. Shares one AXI slave-side write path (AW/W/B) between two masters, m0 and m1.
- Sits upstream of the write-side slave mux, which routes by address.
- Owns only the handshake gating and grant state. A separate data mux, driven by `grant_m0`/`grant_m1`, steers AWADDR/WDATA/etc.
- Holds a grant for exactly one full transaction: AW handshake, W burst through WLAST, then B handshake.

---
 rtl/axi_ic_pkg.sv | 17 +
 rtl/axi_master_arbiter_w_if.sv | 23 ++
 rtl/rr_arb2.sv | 12 +
 rtl/axi_master_arbiter_w.sv | 121 ++++++++++++
 tb/tb_axi_master_arbiter_w.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ic_pkg.sv
// Shared interconnect types: write-arbiter state encoding
// and the AXI BRESP codes used across the fabric.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } st_t;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_master_arbiter_w_if.sv
// AXI write-path handshake bundle (AW/W/B valid/ready + WLAST).
// master: drives AWVALID/WVALID/WLAST/BREADY; slave: the rest.
interface axi_master_arbiter_w_if;

  logic AWVALID;
  logic AWREADY;
  logic WVALID;
  logic WLAST;
  logic WREADY;
  logic BVALID;
  logic BREADY;

  modport master (
    output AWVALID, WVALID, WLAST, BREADY,
    input  AWREADY, WREADY, BVALID
  );

  modport slave (
    input  AWVALID, WVALID, WLAST, BREADY,
    output AWREADY, WREADY, BVALID
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker, purely combinational.
// req: requests; ptr: preferred index on a tie; gnt: one-hot.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/axi_master_arbiter_w.sv
// Round-robin write-channel arbiter: two masters share one AW/W/B
// path. Ports: ACLK/ARESET, m0/m1 (slave view), s (master view),
// grant_m0/grant_m1 (registered one-hot), busy, beat_cnt,
// err_wlast/err_btimeout (sticky).
module axi_master_arbiter_w
  import axi_ic_pkg::*;
#(
  parameter int unsigned BEAT_CNT_WIDTH = 9,
  parameter int unsigned B_TIMEOUT      = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi_master_arbiter_w_if.slave     m0,
  axi_master_arbiter_w_if.slave     m1,
  axi_master_arbiter_w_if.master    s,
  output logic                      grant_m0,
  output logic                      grant_m1,
  output logic                      busy,
  output logic [BEAT_CNT_WIDTH-1:0] beat_cnt,
  output logic                      err_wlast,
  output logic                      err_btimeout
);

  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_MAX =
    {1'b1, {(BEAT_CNT_WIDTH-1){1'b0}}};

  st_t         state;
  logic        rr_ptr;
  logic [31:0] to_cnt;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        in_aw, in_w, in_b;
  logic        aw_hs, w_hs, b_hs;

  assign req = {m1.AWVALID, m0.AWVALID};

  rr_arb2 u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign in_aw = (state == ST_AW);
  assign in_w  = (state == ST_W);
  assign in_b  = (state == ST_B);
  assign busy  = (state != ST_IDLE);

  assign s.AWVALID = in_aw & (grant_m0 & m0.AWVALID |
                              grant_m1 & m1.AWVALID);
  assign s.WVALID  = in_w  & (grant_m0 & m0.WVALID |
                              grant_m1 & m1.WVALID);
  assign s.WLAST   = in_w  & (grant_m0 & m0.WLAST |
                              grant_m1 & m1.WLAST);
  assign s.BREADY  = in_b  & (grant_m0 & m0.BREADY |
                              grant_m1 & m1.BREADY);

  assign m0.AWREADY = in_aw & grant_m0 & s.AWREADY;
  assign m1.AWREADY = in_aw & grant_m1 & s.AWREADY;
  assign m0.WREADY  = in_w  & grant_m0 & s.WREADY;
  assign m1.WREADY  = in_w  & grant_m1 & s.WREADY;
  assign m0.BVALID  = in_b  & grant_m0 & s.BVALID;
  assign m1.BVALID  = in_b  & grant_m1 & s.BVALID;

  assign aw_hs = s.AWVALID & s.AWREADY;
  assign w_hs  = s.WVALID  & s.WREADY;
  assign b_hs  = s.BVALID  & s.BREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= ST_IDLE;
      rr_ptr       <= 1'b0;
      grant_m0     <= 1'b0;
      grant_m1     <= 1'b0;
      beat_cnt     <= '0;
      to_cnt       <= '0;
      err_wlast    <= 1'b0;
      err_btimeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            grant_m0 <= gnt[0];
            grant_m1 <= gnt[1];
            state    <= ST_AW;
          end
        end
        ST_AW: begin
          if (aw_hs) state <= ST_W;
        end
        ST_W: begin
          if (w_hs) begin
            if (beat_cnt != BEAT_MAX)
              beat_cnt <= beat_cnt + 1'b1;
            if (s.WLAST)
              state <= ST_B;
            else if (beat_cnt + 1'b1 == BEAT_MAX)
              err_wlast <= 1'b1;
          end
        end
        ST_B: begin
          if (b_hs) begin
            state    <= ST_IDLE;
            grant_m0 <= 1'b0;
            grant_m1 <= 1'b0;
            beat_cnt <= '0;
            to_cnt   <= '0;
            // next tie goes to the master not just served
            rr_ptr   <= ~grant_m1;
          end else if (B_TIMEOUT != 0 &&
                       to_cnt != B_TIMEOUT) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == B_TIMEOUT - 1)
              err_btimeout <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter_w.sv
// Directed self-checking bench for axi_master_arbiter_w.
// B_TIMEOUT is shortened to 16 to exercise the B timeout.
module tb_axi_master_arbiter_w;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       grant_m0, grant_m1, busy;
  logic [8:0] beat_cnt;
  logic       err_wlast, err_btimeout;
  int         total = 0;
  int         bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_master_arbiter_w_if m0i ();
  axi_master_arbiter_w_if m1i ();
  axi_master_arbiter_w_if si ();

  axi_master_arbiter_w #(
    .BEAT_CNT_WIDTH (9),
    .B_TIMEOUT      (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .m0           (m0i),
    .m1           (m1i),
    .s            (si),
    .grant_m0     (grant_m0),
    .grant_m1     (grant_m1),
    .busy         (busy),
    .beat_cnt     (beat_cnt),
    .err_wlast    (err_wlast),
    .err_btimeout (err_btimeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drv(input int m, input logic aw, input logic w,
                     input logic wl, input logic br);
    if (m == 0) begin
      m0i.AWVALID = aw; m0i.WVALID = w;
      m0i.WLAST = wl;   m0i.BREADY = br;
    end else begin
      m1i.AWVALID = aw; m1i.WVALID = w;
      m1i.WLAST = wl;   m1i.BREADY = br;
    end
  endtask

  function automatic logic [2:0] hs_of(input int m);
    if (m == 0)
      return {m0i.AWREADY, m0i.WREADY, m0i.BVALID};
    return {m1i.AWREADY, m1i.WREADY, m1i.BVALID};
  endfunction

  function automatic logic grant_of(input int m);
    return (m == 0) ? grant_m0 : grant_m1;
  endfunction

  task automatic clr_all();
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    si.AWREADY = 0; si.WREADY = 0; si.BVALID = 0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    #2;
    clr_all();
    ARESET = 1'b0;
  endtask

  // Entered one step after the grant edge; ends at a negedge in IDLE.
  task automatic run_tx(input int m, input int beats);
    int o;
    logic [2:0] r, ro;
    o = 1 - m;
    chk("tx_gnt", grant_of(m), 1);
    chk("tx_gnt_o", grant_of(o), 0);
    drv(m, 1, 1, 0, 0);
    si.AWREADY = 1;
    @(negedge ACLK);
    r = hs_of(m); ro = hs_of(o);
    chk("aw_svld", si.AWVALID, 1);
    chk("aw_rdy", r[2], 1);
    chk("aw_rdy_o", ro[2], 0);
    chk("aw_no_w", si.WVALID, 0);
    chk("aw_no_wrdy", r[1], 0);
    cyc();
    drv(m, 0, 0, 0, 0);
    si.AWREADY = 0; si.WREADY = 1;
    @(negedge ACLK);
    chk("w_bubble", si.WVALID, 0);
    cyc();
    chk("w_bub_cnt", beat_cnt, 0);
    for (int i = 1; i <= beats; i++) begin
      drv(m, 0, 1, (i == beats), 0);
      @(negedge ACLK);
      r = hs_of(m); ro = hs_of(o);
      chk("w_svld", si.WVALID, 1);
      chk("w_rdy", r[1], 1);
      chk("w_rdy_o", ro[1], 0);
      chk("w_last", si.WLAST, (i == beats));
      cyc();
      chk("beat_cnt", beat_cnt, i);
    end
    drv(m, 0, 0, 0, 1);
    si.WREADY = 0; si.BVALID = 1;
    @(negedge ACLK);
    r = hs_of(m); ro = hs_of(o);
    chk("b_vld", r[0], 1);
    chk("b_vld_o", ro[0], 0);
    chk("b_srdy", si.BREADY, 1);
    chk("b_busy", busy, 1);
    cyc();
    drv(m, 0, 0, 0, 0);
    si.BVALID = 0;
    @(negedge ACLK);
    chk("idle_busy", busy, 0);
    chk("idle_g0", grant_m0, 0);
    chk("idle_g1", grant_m1, 0);
    chk("idle_beat", beat_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0] r;
    ARESET = 1'b1;
    clr_all();
    drv(0, 1, 1, 1, 1);
    si.AWREADY = 1; si.WREADY = 1; si.BVALID = 1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    r = hs_of(0);
    chk("rst_g0", grant_m0, 0);
    chk("rst_g1", grant_m1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_errs", {err_wlast, err_btimeout}, 0);
    chk("rst_m0hs", r, 0);
    chk("rst_shs", {si.AWVALID, si.WVALID, si.BREADY}, 0);
    clr_all();
    ARESET = 1'b0;

    // single m0 write, 4 beats
    drv(0, 1, 0, 0, 0);
    #1;
    chk("idle_no_aw", si.AWVALID, 0);
    chk("idle_no_g", grant_m0, 0);
    cyc();
    run_tx(0, 4);
    // rr_ptr now favours m1
    drv(0, 1, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    cyc();
    chk("rr_ptr1", grant_m1, 1);
    chk("rr_ptr1_g0", grant_m0, 0);
    do_reset();

    // simultaneous requests: m0, m1, then m0 again
    @(negedge ACLK);
    drv(0, 1, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    cyc();
    run_tx(0, 2);
    cyc();
    run_tx(1, 3);
    drv(0, 1, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    cyc();
    run_tx(0, 1);
    drv(1, 0, 0, 0, 0);

    // m1 granted while m0 holds WVALID
    drv(0, 0, 1, 0, 0);
    drv(1, 1, 0, 0, 0);
    cyc();
    run_tx(1, 3);
    drv(0, 0, 0, 0, 0);

    // WLAST never arrives
    drv(0, 1, 0, 0, 0);
    cyc();
    chk("ovf_gnt", grant_m0, 1);
    si.AWREADY = 1;
    cyc();
    drv(0, 0, 1, 0, 1);
    si.AWREADY = 0; si.WREADY = 1; si.BVALID = 1;
    repeat (255) cyc();
    chk("ovf_255", beat_cnt, 255);
    chk("ovf_err0", err_wlast, 0);
    cyc();
    chk("ovf_256", beat_cnt, 256);
    chk("ovf_err1", err_wlast, 1);
    chk("ovf_busy", busy, 1);
    @(negedge ACLK);
    r = hs_of(0);
    chk("ovf_no_b", r[0], 0);
    chk("ovf_no_brdy", si.BREADY, 0);
    chk("ovf_in_w", si.WVALID, 1);
    repeat (3) cyc();
    chk("ovf_sat", beat_cnt, 256);
    chk("ovf_sticky", err_wlast, 1);
    do_reset();
    chk("ovf_rst_err", err_wlast, 0);

    // B timeout with B_TIMEOUT=16
    @(negedge ACLK);
    drv(0, 1, 0, 0, 0);
    cyc();
    chk("bto_gnt", grant_m0, 1);
    si.AWREADY = 1;
    cyc();
    drv(0, 0, 1, 1, 0);
    si.AWREADY = 0; si.WREADY = 1;
    cyc();
    drv(0, 0, 0, 0, 1);
    si.WREADY = 0;
    repeat (15) cyc();
    chk("bto_15", err_btimeout, 0);
    cyc();
    chk("bto_16", err_btimeout, 1);
    chk("bto_busy", busy, 1);
    repeat (4) cyc();
    chk("bto_wait", busy, 1);
    si.BVALID = 1;
    @(negedge ACLK);
    r = hs_of(0);
    chk("bto_bvld", r[0], 1);
    cyc();
    si.BVALID = 0;
    drv(0, 0, 0, 0, 0);
    chk("bto_idle", busy, 0);
    chk("bto_sticky", err_btimeout, 1);

    // async reset during W at beat 2
    @(negedge ACLK);
    drv(0, 1, 0, 0, 0);
    cyc();
    si.AWREADY = 1;
    cyc();
    drv(0, 0, 1, 0, 0);
    si.AWREADY = 0; si.WREADY = 1;
    cyc();
    cyc();
    chk("ar_beat2", beat_cnt, 2);
    #2;
    ARESET = 1'b1;
    #1;
    r = hs_of(0);
    chk("ar_g0", grant_m0, 0);
    chk("ar_busy", busy, 0);
    chk("ar_beat", beat_cnt, 0);
    chk("ar_swv", si.WVALID, 0);
    chk("ar_wrdy", r[1], 0);
    chk("ar_err", err_btimeout, 0);
    clr_all();
    #1;
    ARESET = 1'b0;
    drv(1, 1, 0, 0, 0);
    cyc();
    chk("ar_g0_after", grant_m0, 0);
    run_tx(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
